// File: rtl/alu_seq.sv
// Sequential ALU: one valid/ready command in, one registered result + zero flag out.
// Define ALU_MUL_EN to build opcode 111 as an iterative shift-add multiply (else NOP).
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           operation,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 zero,
  output logic                 busy
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  // state | meaning
  // IDLE  | waiting for a command, in_ready high
  // EXEC  | shift-add multiply, one multiplier bit per cycle
  // DONE  | result valid, held until out_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [RW-1:0]    r_result;
  logic             r_zero;
  logic [RW-1:0]    w_alu_res;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_is_mul;

  assign w_sum  = {1'b0, A} + {1'b0, B};
  assign w_diff = {1'b0, A} - {1'b0, B};

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [RW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [RW-1:0]    w_addend;
  logic [RW-1:0]    w_acc_next;
  logic             w_last;

  assign w_is_mul   = (operation == 3'b111);
  assign w_addend   = r_b[r_cnt[CW-2:0]] ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0;
  assign w_acc_next = r_acc + w_addend;
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
`else
  assign w_is_mul = 1'b0;
`endif

  // SUB keeps its WIDTH+1-bit borrow as the sign so $signed(result) is the true difference
  always_comb begin
    w_alu_res = '0;
    case (operation)
      3'b000:  w_alu_res = {{(WIDTH-1){1'b0}}, w_sum};
      3'b001:  w_alu_res = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
      3'b010:  w_alu_res = {{WIDTH{1'b0}}, A & B};
      3'b011:  w_alu_res = {{WIDTH{1'b0}}, A | B};
      3'b100:  w_alu_res = {{WIDTH{1'b0}}, A ^ B};
      3'b101:  w_alu_res = {{WIDTH{1'b0}}, ~A};
      3'b110:  w_alu_res = {{(RW-1){1'b0}}, (A < B)};
      default: w_alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_next = w_is_mul ? S_EXEC : S_DONE;
`ifdef ALU_MUL_EN
      S_EXEC: if (w_last) w_state_next = S_DONE;
`else
      S_EXEC: w_state_next = S_IDLE;
`endif
      S_DONE: if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
`ifdef ALU_MUL_EN
    busy      = (r_state == S_EXEC);
`else
    busy      = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
`ifdef ALU_MUL_EN
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
`endif
    end else begin
      if (r_state == S_IDLE && in_valid) begin
`ifdef ALU_MUL_EN
        if (w_is_mul) begin
          r_a   <= A;
          r_b   <= B;
          r_acc <= '0;
          r_cnt <= '0;
        end else
`endif
        begin
          r_result <= w_alu_res;
          r_zero   <= (w_alu_res == '0);
        end
      end
`ifdef ALU_MUL_EN
      if (r_state == S_EXEC) begin
        if (w_last) begin
          r_result <= w_acc_next;
          r_zero   <= (w_acc_next == '0);
        end else begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CW'(1);
        end
      end
`endif
    end
  end

  assign result = r_result;
  assign zero   = r_zero;

endmodule
